// File: rtl/uart_pkg.sv
// uart_pkg: shared parity-mode encodings, rx frame-check FSM states and data-width limits
package uart_pkg;
  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;
  localparam int DW_MIN = 5;
  localparam int DW_MAX = 9;
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAR, S_STOP1, S_STOP2} state_t;
  function automatic logic exp_parity(input logic [1:0] mode, input logic acc);
    return mode == PAR_EVEN ? acc : mode == PAR_ODD ? ~acc : mode == PAR_MARK;
  endfunction
endpackage

// File: rtl/uart_sat_counter.sv
// uart_sat_counter: saturating event counter (clk, rst async low, increment, clear wins, count)
module uart_sat_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 increment,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clear) count <= '0;
    else if (increment && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check: per-bit parity/stop checker with per-frame flags and saturating error counters
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 bit_valid,
  input  logic                 sampled_bit,
  input  logic                 par_en,
  input  logic [1:0]           par_mode,
  input  logic                 two_stop,
  input  logic                 clr_err,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 par_error,
  output logic                 stop_error,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic [CNT_WIDTH-1:0] stop_err_cnt
);
  localparam int BW = $clog2(DATA_WIDTH);
  if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX) begin : g_bad_width
    $error("uart_rx_frame_check: DATA_WIDTH out of range");
  end
  state_t         state, next;
  logic [BW-1:0]  cnt;
  logic           acc, par_flag, stop_flag, stop_nxt, fin;
  logic           cfg_par_en, cfg_two_stop;
  logic [1:0]     cfg_mode;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    fin  = 1'b0;
    if (frame_start) next = S_DATA;
    else if (bit_valid)
      case (state)
        S_DATA:  next = cnt == BW'(DATA_WIDTH - 1) ? (cfg_par_en ? S_PAR : S_STOP1) : S_DATA;
        S_PAR:   next = S_STOP1;
        S_STOP1: begin
          next = cfg_two_stop ? S_STOP2 : S_IDLE;
          fin  = !cfg_two_stop;
        end
        S_STOP2: begin
          next = S_IDLE;
          fin  = 1'b1;
        end
        default: next = state;
      endcase
  end
  assign busy     = state != S_IDLE;
  assign stop_nxt = stop_flag | ((state == S_STOP1 || state == S_STOP2) && bit_valid && !sampled_bit);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt          <= '0;
      acc          <= 1'b0;
      par_flag     <= 1'b0;
      stop_flag    <= 1'b0;
      cfg_par_en   <= 1'b0;
      cfg_two_stop <= 1'b0;
      cfg_mode     <= PAR_EVEN;
      frame_done   <= 1'b0;
      par_error    <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      frame_done <= fin;
      if (fin) begin
        par_error  <= par_flag;
        stop_error <= stop_nxt;
      end
      if (frame_start) begin
        cnt          <= '0;
        acc          <= 1'b0;
        par_flag     <= 1'b0;
        stop_flag    <= 1'b0;
        cfg_par_en   <= par_en;
        cfg_two_stop <= two_stop;
        cfg_mode     <= par_mode;
      end else if (bit_valid) begin
        if (state == S_DATA) begin
          acc <= acc ^ sampled_bit;
          cnt <= cnt + 1'b1;
        end
        if (state == S_PAR) par_flag <= sampled_bit != exp_parity(cfg_mode, acc);
        if (state == S_STOP1 || state == S_STOP2) stop_flag <= stop_nxt;
      end
    end
  uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
    .clk(clk), .rst(rst), .increment(fin && par_flag), .clear(clr_err), .count(par_err_cnt)
  );
  uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stop_cnt (
    .clk(clk), .rst(rst), .increment(fin && stop_nxt), .clear(clr_err), .count(stop_err_cnt)
  );
endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb_uart_rx_frame_check: directed self-checking bench for default and 2-bit-counter instances
module tb_uart_rx_frame_check;
  logic clk = 1'b0, rst = 1'b0;
  logic frame_start = 0, bit_valid = 0, sampled_bit = 0, par_en = 0, two_stop = 0, clr_err = 0;
  logic [1:0] par_mode = 2'b00;
  logic busy8, done8, pe8, se8, busy2, done2, pe2, se2;
  logic [7:0] pc8, sc8;
  logic [1:0] pc2, sc2;
  int checks = 0, errors = 0, dc = 0, dc0;
  always #5 clk = ~clk;
  always @(posedge clk) if (done8) dc <= dc + 1;
  uart_rx_frame_check u8 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid), .sampled_bit(sampled_bit),
    .par_en(par_en), .par_mode(par_mode), .two_stop(two_stop), .clr_err(clr_err), .busy(busy8),
    .frame_done(done8), .par_error(pe8), .stop_error(se8), .par_err_cnt(pc8), .stop_err_cnt(sc8)
  );
  uart_rx_frame_check #(.CNT_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid), .sampled_bit(sampled_bit),
    .par_en(par_en), .par_mode(par_mode), .two_stop(two_stop), .clr_err(clr_err), .busy(busy2),
    .frame_done(done2), .par_error(pe2), .stop_error(se2), .par_err_cnt(pc2), .stop_err_cnt(sc2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    sampled_bit = b;
    tick();
    bit_valid = 1'b0;
  endtask
  task automatic start(input logic pe, input logic [1:0] pm, input logic ts, input logic bv);
    par_en = pe;
    par_mode = pm;
    two_stop = ts;
    frame_start = 1'b1;
    bit_valid = bv;
    sampled_bit = 1'b1;
    tick();
    frame_start = 1'b0;
    bit_valid = 1'b0;
    chk("busy_after_start", busy8, 1);
    par_en = ~pe;
    par_mode = ~pm;
    two_stop = ~ts;
  endtask
  task automatic body(input logic [7:0] d, input logic pe, input logic ts, input logic pb,
                      input logic s1, input logic s2, input logic clr_last);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pe) send_bit(pb);
    if (ts) begin
      send_bit(s1);
      clr_err = clr_last;
      send_bit(s2);
    end else begin
      clr_err = clr_last;
      send_bit(s1);
    end
    clr_err = 1'b0;
  endtask
  task automatic frame(input logic [7:0] d, input logic pe, input logic [1:0] pm, input logic ts,
                       input logic pb, input logic s1, input logic s2, input logic clr_last);
    start(pe, pm, ts, 1'b0);
    body(d, pe, ts, pb, s1, s2, clr_last);
  endtask
  task automatic expect_done(input string tag, input logic pe, input logic se, input int pc, input int sc);
    chk({tag, "_done"}, done8, 1);
    chk({tag, "_busy"}, busy8, 0);
    chk({tag, "_par_error"}, pe8, pe);
    chk({tag, "_stop_error"}, se8, se);
    chk({tag, "_par_cnt"}, pc8, pc);
    chk({tag, "_stop_cnt"}, sc8, sc);
    chk({tag, "_par_cnt2"}, pc2, pc > 3 ? 3 : pc);
    chk({tag, "_stop_cnt2"}, sc2, sc > 3 ? 3 : sc);
    tick();
    chk({tag, "_done_pulse"}, done8, 0);
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_busy", busy8, 0);
    chk("rst_flags", {done8, pe8, se8}, 0);
    chk("rst_cnts", {pc8, sc8, pc2, sc2}, 0);
    rst = 1'b1;
    tick();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("idle_bits_busy", busy8, 0);
    chk("idle_bits_done", done8, 0);
    frame(8'hA5, 1, 2'b00, 0, 0, 1, 1, 0);
    expect_done("even_ok", 0, 0, 0, 0);
    frame(8'hA5, 1, 2'b01, 0, 0, 1, 1, 0);
    expect_done("odd_bad", 1, 0, 1, 0);
    frame(8'hA5, 1, 2'b01, 0, 1, 1, 1, 0);
    expect_done("odd_ok", 0, 0, 1, 0);
    frame(8'h00, 1, 2'b10, 0, 0, 1, 1, 0);
    expect_done("mark_bad", 1, 0, 2, 0);
    frame(8'h00, 1, 2'b11, 0, 0, 1, 1, 0);
    expect_done("space_ok", 0, 0, 2, 0);
    frame(8'h3C, 1, 2'b00, 1, 0, 1, 0, 0);
    expect_done("stop2_bad", 0, 1, 2, 1);
    dc0 = dc;
    start(1, 2'b01, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("abort_busy", busy8, 1);
    chk("abort_flags_hold", {pe8, se8}, 2'b01);
    start(1, 2'b00, 0, 1'b1);
    body(8'hA5, 1, 0, 0, 1, 1, 0);
    expect_done("restart", 0, 0, 2, 1);
    chk("abort_single_done", dc - dc0, 1);
    frame(8'hFF, 0, 2'b01, 1, 0, 1, 1, 0);
    expect_done("nopar_2stop", 0, 0, 2, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_cnts", {pc8, sc8, pc2, sc2}, 0);
    chk("clr_flags_busy", {pe8, se8, busy8}, 0);
    for (int k = 1; k <= 5; k++) begin
      frame(8'h00, 1, 2'b10, 0, 0, 1, 1, 0);
      expect_done("sat", 1, 0, k, 0);
    end
    frame(8'h00, 1, 2'b10, 0, 0, 1, 1, 1);
    expect_done("clr_on_inc", 1, 0, 0, 0);
    start(1, 2'b00, 0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", {busy8, busy2}, 0);
    chk("async_rst_flags", {done8, pe8, se8}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    frame(8'h3C, 1, 2'b00, 0, 0, 0, 1, 0);
    expect_done("after_rst", 0, 1, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Serial frame checker for the UART receive path. It accumulates parity bit-by-bit as `sampled_bit` strobes arrive, checks the parity bit in one of four configurable modes, and validates one or two stop bits. It reports per-frame parity and stop (framing) errors plus saturating error counters. It sits between the RX sampler/FSM and the RX register interface, and it generalises the fixed-width, even/odd, parallel-data parity checker.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5..9.
- `CNT_WIDTH`, default 8: width of each error counter.
- `clk`, in, 1: clock, rising-edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `frame_start`, in, 1: one-cycle pulse when the start bit is accepted; arms or re-arms the checker.
- `bit_valid`, in, 1: one-cycle strobe; `sampled_bit` is valid in that cycle.
- `sampled_bit`, in, 1: received bit (data, parity or stop).
- `par_en`, in, 1: parity bit present.
- `par_mode`, in, 2: 00 even, 01 odd, 10 mark, 11 space.
- `two_stop`, in, 1: 1 selects two stop bits, 0 selects one.
- `clr_err`, in, 1: synchronous clear of both counters.
- `busy`, out, 1: frame in progress.
- `frame_done`, out, 1: one-cycle pulse at frame end.
- `par_error`, out, 1: parity result of the last completed frame.
- `stop_error`, out, 1: stop-bit result of the last completed frame.
- `par_err_cnt`, out, `CNT_WIDTH`: saturating parity error count.
- `stop_err_cnt`, out, `CNT_WIDTH`: saturating stop error count.

## Operation
- **Reset values:** all outputs 0; FSM in IDLE; accumulator and bit counter 0.
- **Config capture:** `par_en`, `par_mode` and `two_stop` are registered on `frame_start`. Changes to them mid-frame have no effect.
- **FSM states:** IDLE, DATA, PAR, STOP1, STOP2.
  - IDLE -> DATA on `frame_start`. The accumulator and bit counter clear, and the stop-error flag clears.
  - DATA: each `bit_valid` XORs `sampled_bit` into the accumulator and increments the counter. After `DATA_WIDTH` bits, go to PAR if `par_en`, else STOP1.
  - PAR: one `bit_valid`, then go to STOP1. The captured parity bit is compared against the expected value:
    - even: expected = accumulator;
    - odd: expected = ~accumulator;
    - mark: expected = 1;
    - space: expected = 0.
    - A mismatch sets the internal parity flag.
  - STOP1: one `bit_valid`; a 0 sets the internal stop flag. Then go to STOP2 if `two_stop`, else end the frame.
  - STOP2: one `bit_valid`; a 0 sets the stop flag. Then end the frame.
- **End of frame:** the FSM returns to IDLE. `frame_done` pulses, and `par_error`/`stop_error` load the internal flags. `par_error` is 0 whenever `par_en` was 0 for that frame.
- **Counters:** each counter increments by 1 per frame whose corresponding error is set, and saturates at all-ones (no wrap).
- **Flag hold:** `par_error` and `stop_error` hold their values until the next `frame_done`.
- **Boundary conditions:**
  - `bit_valid` in IDLE is ignored.
  - `frame_start` while busy aborts the current frame and restarts it. There is no `frame_done` for the aborted frame, the counters are unchanged, and the output flags keep their previous values.
  - `frame_start` and `bit_valid` in the same cycle: `frame_start` wins and the bit is discarded.
  - `clr_err` in the same cycle as an increment: clear wins and the counter goes to 0.
  - `clr_err` does not affect `par_error`, `stop_error` or the FSM.
  - Reset mid-frame returns everything to reset values immediately (asynchronous).

## Timing
- `busy` rises in the cycle after `frame_start` and falls together with the `frame_done` rise.
- Latency: `frame_done`, `par_error`, `stop_error` and the counter updates are all registered on the clock edge that samples the final stop bit's `bit_valid`. They are visible in the next cycle.
- `frame_done` is high for exactly one cycle.
- Minimum spacing between `bit_valid` strobes is 1 cycle; back-to-back strobes are legal.
- A new `frame_start` is legal in the cycle `frame_done` is high.
- Total strobes per frame: `DATA_WIDTH` + `par_en` + 1 + `two_stop`.

## Structure
- Shared package `uart_pkg` holds:
  - the `par_mode` encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE);
  - the FSM state typedef;
  - the DATA_WIDTH legal-range constants.
- Sub-module `uart_sat_counter` (parameter `CNT_WIDTH`; ports: increment, clear, count) is instantiated twice, once per error counter.
- The FSM, bit counter and accumulator live in the top module.

## Test plan
- Default widths, even, one stop. Send data 0xA5, parity bit 0, stop 1 -> `frame_done` pulses one cycle after the stop strobe; `par_error`=0, `stop_error`=0, both counters 0.
- Odd mode. Send data 0xA5, parity bit 0 -> `par_error`=1, `par_err_cnt`=1. Same frame with parity bit 1 -> `par_error`=0, count stays 1.
- Mark mode. Send 0x00, parity bit 0 -> `par_error`=1. Space mode, same frame -> `par_error`=0.
- `two_stop`=1. Send 0x3C, even parity 0, stops 1 then 0 -> `stop_error`=1, `stop_err_cnt`=1. Then `par_en`=0 with 8 data bits and stops 1,1 -> no errors.
- Send `frame_start`, 4 data strobes, then `frame_start` again with a full good frame -> exactly one `frame_done`, counters unchanged. Also send `bit_valid` in IDLE -> no effect.
- `CNT_WIDTH`=2. Send 5 parity-error frames -> `par_err_cnt`=3 (saturated). Assert `clr_err` on the 6th error's final edge -> count 0. Also assert reset mid-frame -> all outputs 0 at once.
